// File: rtl/alu_op_arbiter.sv
// Two-requester front end for a shared add/sub/compare datapath: arbitrate, run one op, return a tagged response.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with req0 winning ties.
module alu_op_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_ci,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_ci,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_flag,
  output logic [2:0]   rsp_cmp,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic         alu_borin,
  output logic         alu_oprtn1,
  output logic         alu_oprtn2,
  output logic         alu_oprtn3,
  input  logic [N-1:0] alu_sum,
  input  logic [N-1:0] alu_diff,
  input  logic         alu_cout,
  input  logic         alu_borout,
  input  logic         alu_aisbig,
  input  logic         alu_bisbig,
  input  logic         alu_equal
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e       state_q;
  logic [1:0]   op_q;
  logic         id_q;
  logic         gnt0, gnt1, take;
  logic [1:0]   sel_op;
  logic [N-1:0] sel_a, sel_b;
  logic         sel_ci;

`ifdef ARB_RR_EN
  logic rr_q;

  // rr_q names the requester that wins a tie.
  assign gnt0 = req0_valid & (~req1_valid | ~rr_q);
  assign gnt1 = req1_valid & (~req0_valid | rr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (take) begin
      rr_q <= ~req1_ready;
    end
  end
`else
  assign gnt0 = req0_valid;
  assign gnt1 = req1_valid & ~req0_valid;
`endif

  assign req0_ready = (state_q == IDLE) & gnt0;
  assign req1_ready = (state_q == IDLE) & gnt1;
  assign take       = req0_ready | req1_ready;

  assign sel_op = req1_ready ? req1_op : req0_op;
  assign sel_a  = req1_ready ? req1_a  : req0_a;
  assign sel_b  = req1_ready ? req1_b  : req0_b;
  assign sel_ci = req1_ready ? req1_ci : req0_ci;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      id_q       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_borin  <= 1'b0;
      alu_oprtn1 <= 1'b0;
      alu_oprtn2 <= 1'b0;
      alu_oprtn3 <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_cmp    <= 3'b000;
      rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q    <= EXEC;
            op_q       <= sel_op;
            id_q       <= req1_ready;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_cin    <= (sel_op == OP_ADD) & sel_ci;
            alu_borin  <= (sel_op == OP_SUB) & sel_ci;
            alu_oprtn1 <= (sel_op == OP_ADD);
            alu_oprtn2 <= (sel_op == OP_SUB);
            alu_oprtn3 <= (sel_op == OP_CMP);
          end
        end
        EXEC: begin
          // Datapath outputs are valid for the enable pulsed this cycle.
          state_q    <= RESP;
          alu_cin    <= 1'b0;
          alu_borin  <= 1'b0;
          alu_oprtn1 <= 1'b0;
          alu_oprtn2 <= 1'b0;
          alu_oprtn3 <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_id     <= id_q;
          rsp_result <= (op_q == OP_ADD) ? alu_sum :
                        (op_q == OP_SUB) ? alu_diff : '0;
          rsp_flag   <= ((op_q == OP_ADD) & alu_cout) | ((op_q == OP_SUB) & alu_borout);
          rsp_cmp    <= (op_q == OP_CMP) ? {alu_aisbig, alu_bisbig, alu_equal} : 3'b000;
          rsp_err    <= (op_q == OP_ILL);
        end
        RESP: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Randomized bench for alu_op_arbiter with a behavioural datapath and response model.
// Honours ARB_RR_EN the same way as the design build.
module tb_alu_op_arbiter;

  localparam int N = 4;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req0_ci;
  logic [1:0]   req0_op;
  logic [N-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_ci;
  logic [1:0]   req1_op;
  logic [N-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err;
  logic [N-1:0] rsp_result;
  logic [2:0]   rsp_cmp;
  logic [N-1:0] alu_a, alu_b, alu_sum, alu_diff;
  logic         alu_cin, alu_borin, alu_oprtn1, alu_oprtn2, alu_oprtn3;
  logic         alu_cout, alu_borout, alu_aisbig, alu_bisbig, alu_equal;

  alu_op_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_borin(alu_borin),
    .alu_oprtn1(alu_oprtn1), .alu_oprtn2(alu_oprtn2), .alu_oprtn3(alu_oprtn3),
    .alu_sum(alu_sum), .alu_diff(alu_diff), .alu_cout(alu_cout), .alu_borout(alu_borout),
    .alu_aisbig(alu_aisbig), .alu_bisbig(alu_bisbig), .alu_equal(alu_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for add_sub_comp: outputs only meaningful while its enable is high.
  int dp_s, dp_d;
  always_comb begin
    dp_s       = int'(alu_a) + int'(alu_b) + int'(alu_cin);
    dp_d       = int'(alu_a) - int'(alu_b) - int'(alu_borin);
    alu_sum    = alu_oprtn1 ? dp_s[N-1:0] : '0;
    alu_cout   = alu_oprtn1 && (dp_s >= (1 << N));
    alu_diff   = alu_oprtn2 ? dp_d[N-1:0] : '0;
    alu_borout = alu_oprtn2 && (dp_d < 0);
    alu_aisbig = alu_oprtn3 && (alu_a > alu_b);
    alu_bisbig = alu_oprtn3 && (alu_b > alu_a);
    alu_equal  = alu_oprtn3 && (alu_a == alu_b);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  logic         v [2];
  logic [1:0]   op_r [2];
  logic [N-1:0] a_r [2];
  logic [N-1:0] b_r [2];
  logic         ci_r [2];
  int           pref = 0;

  task automatic drive_reqs();
    req0_valid = v[0]; req0_op = op_r[0]; req0_a = a_r[0]; req0_b = b_r[0]; req0_ci = ci_r[0];
    req1_valid = v[1]; req1_op = op_r[1]; req1_a = a_r[1]; req1_b = b_r[1]; req1_ci = ci_r[1];
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input int a, input int b, input int ci);
    op_r[r] = op; a_r[r] = a[N-1:0]; b_r[r] = b[N-1:0]; ci_r[r] = ci[0]; v[r] = 1'b1;
  endtask

  task automatic rand_req(input int r);
    set_req(r, 2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1));
  endtask

  // Response expected from the arithmetic rules, independent of any datapath encoding.
  task automatic predict(input logic [1:0] op, input int a, input int b, input int ci,
                         output logic [N-1:0] r, output logic f, output logic [2:0] c,
                         output logic e);
    int s;
    r = '0; f = 1'b0; c = 3'b000; e = 1'b0;
    case (op)
      2'b00: begin s = a + b + ci; r = s[N-1:0]; f = (s >= 16); end
      2'b01: begin s = a - b - ci; r = s[N-1:0]; f = (s < 0); end
      2'b10: c = {a > b, b > a, a == b};
      default: e = 1'b1;
    endcase
  endtask

  task automatic run_txn(input int hold, input bit glitch);
    int w;
    logic [N-1:0] er;
    logic ef, ee;
    logic [2:0] ec, en;
    drive_reqs();
    #1;
    if (v[0] && v[1]) begin
`ifdef ARB_RR_EN
      w = pref;
`else
      w = 0;
`endif
    end else begin
      w = v[1] ? 1 : 0;
    end
    chk("ready0", 32'(req0_ready), 32'(w == 0));
    chk("ready1", 32'(req1_ready), 32'(w == 1));
    predict(op_r[w], int'(a_r[w]), int'(b_r[w]), int'(ci_r[w]), er, ef, ec, ee);
    en = (op_r[w] == 2'b00) ? 3'b001 : (op_r[w] == 2'b01) ? 3'b010 :
         (op_r[w] == 2'b10) ? 3'b100 : 3'b000;
`ifdef ARB_RR_EN
    pref = 1 - w;
`endif
    @(posedge clk); #1;
    v[w] = 1'b0;
    drive_reqs();
    @(negedge clk);
    chk("exec_oprtn", 32'({alu_oprtn3, alu_oprtn2, alu_oprtn1}), 32'(en));
    chk("exec_a", 32'(alu_a), 32'(a_r[w]));
    chk("exec_b", 32'(alu_b), 32'(b_r[w]));
    chk("exec_cin", 32'(alu_cin), 32'((op_r[w] == 2'b00) && ci_r[w]));
    chk("exec_borin", 32'(alu_borin), 32'((op_r[w] == 2'b01) && ci_r[w]));
    chk("exec_rdy", 32'({req1_ready, req0_ready}), 32'(0));
    chk("exec_rspv", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'(1));
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_result", 32'(rsp_result), 32'(er));
      chk("rsp_flag", 32'(rsp_flag), 32'(ef));
      chk("rsp_cmp", 32'(rsp_cmp), 32'(ec));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      chk("resp_oprtn", 32'({alu_oprtn3, alu_oprtn2, alu_oprtn1}), 32'(0));
      chk("resp_rdy", 32'({req1_ready, req0_ready}), 32'(0));
      if (glitch && i == 0) begin v[w] = 1'b1; drive_reqs(); end
      if (glitch && i == 1) begin v[w] = 1'b0; drive_reqs(); end
    end
    rsp_ready = 1'b1;
    #1;
    chk("ack_rdy", 32'({req1_ready, req0_ready}), 32'(0));
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 2; r++) set_req(r, 2'b00, 0, 0, 0);
    v[0] = 1'b0; v[1] = 1'b0;
    drive_reqs();
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rspv", 32'(rsp_valid), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_oprtn", 32'({alu_oprtn3, alu_oprtn2, alu_oprtn1}), 32'(0));
    chk("rst_result", 32'(rsp_result), 32'(0));
    chk("rst_rdy", 32'({req1_ready, req0_ready}), 32'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);

    set_req(0, 2'b00, 9, 8, 1);
    run_txn(0, 1'b0);
    set_req(1, 2'b01, 3, 5, 0);
    run_txn(5, 1'b0);
    set_req(0, 2'b10, 7, 7, 1);
    run_txn(0, 1'b0);
    set_req(1, 2'b11, 12, 4, 1);
    run_txn(2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rspv", 32'(rsp_valid), 32'(0));
      chk("idle_oprtn", 32'({alu_oprtn3, alu_oprtn2, alu_oprtn1}), 32'(0));
    end

    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 2; r++) if (!v[r]) rand_req(r);
      run_txn(0, 1'b0);
    end
    v[0] = 1'b0; v[1] = 1'b0;
    drive_reqs();
    @(negedge clk);

    set_req(0, 2'b00, 11, 6, 1);
    drive_reqs();
    @(posedge clk); #1;
    v[0] = 1'b0;
    drive_reqs();
    @(negedge clk);
    chk("pre_rst_oprtn1", 32'(alu_oprtn1), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rspv", 32'(rsp_valid), 32'(0));
    chk("arst_oprtn", 32'({alu_oprtn3, alu_oprtn2, alu_oprtn1}), 32'(0));
    chk("arst_alu_a", 32'(alu_a), 32'(0));
    chk("arst_cin", 32'(alu_cin), 32'(0));
    #1 rst_n = 1'b1;
    pref = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rspv", 32'(rsp_valid), 32'(0));
    end
    set_req(1, 2'b00, 15, 1, 0);
    run_txn(1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < 2; r++) if (!v[r] && ($urandom_range(0, 1) == 1)) rand_req(r);
      if (!v[0] && !v[1]) rand_req($urandom_range(0, 1));
      run_txn($urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
